// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - E-stage request and HI/LO result bundle for the MDU sequencer
interface mdu_sequencer_if;
    logic        MDU_i_Start;
    logic [2:0]  MDU_i_Op;
    logic [31:0] MDU_i_A;
    logic [31:0] MDU_i_B;
    logic        MDU_i_ReadHi;
    logic        MDU_o_Busy;
    logic        MDU_o_Occupied;
    logic [31:0] MDU_o_HI;
    logic [31:0] MDU_o_LO;
    logic [31:0] MDU_o_Result;

    modport master (
        output MDU_i_Start, MDU_i_Op, MDU_i_A, MDU_i_B, MDU_i_ReadHi,
        input  MDU_o_Busy, MDU_o_Occupied, MDU_o_HI, MDU_o_LO, MDU_o_Result
    );

    modport slave (
        input  MDU_i_Start, MDU_i_Op, MDU_i_A, MDU_i_B, MDU_i_ReadHi,
        output MDU_o_Busy, MDU_o_Occupied, MDU_o_HI, MDU_o_LO, MDU_o_Result
    );
endinterface

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - fixed-latency multiply/divide sequencer with committed HI/LO
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    mdu_sequencer_if.slave mdu
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [3:0] MULT_N   = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N    = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ph_q, ph_d, pl_q, pl_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        wr_q, wr_d;

    logic [31:0] a, b;
    logic [63:0] prod_s, prod_u;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign a = mdu.MDU_i_A;
    assign b = mdu.MDU_i_B;

    // Division works on magnitudes so the signed overflow case falls out naturally;
    // a zero divisor is replaced by 1 only to keep the datapath defined.
    always_comb begin
        prod_s     = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u     = {32'd0, a} * {32'd0, b};
        div_signed = (mdu.MDU_i_Op == OP_DIV);
        a_neg      = div_signed & a[31];
        b_neg      = div_signed & b[31];
        a_mag      = a_neg ? (~a + 32'd1) : a;
        b_mag      = (b == 32'd0) ? 32'd1 : (b_neg ? (~b + 32'd1) : b);
        q_mag      = a_mag / b_mag;
        r_mag      = a_mag % b_mag;
        quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (mdu.MDU_i_Start) begin
                    case (mdu.MDU_i_Op)
                        OP_MULT: begin
                            {ph_d, pl_d} = prod_s;
                            wr_d         = 1'b1;
                            cnt_d        = MULT_N;
                            state_d      = RUN;
                        end
                        OP_MULTU: begin
                            {ph_d, pl_d} = prod_u;
                            wr_d         = 1'b1;
                            cnt_d        = MULT_N;
                            state_d      = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pl_d    = quot;
                            ph_d    = rem;
                            wr_d    = (b != 32'd0);
                            cnt_d   = DIV_N;
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                    if (wr_q) begin
                        hi_d = ph_q;
                        lo_d = pl_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ph_q    <= 32'd0;
            pl_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wr_q    <= wr_d;
        end
    end

    assign mdu.MDU_o_Busy     = (state_q == RUN);
    assign mdu.MDU_o_Occupied = (state_q == RUN) |
                                (mdu.MDU_i_Start & (mdu.MDU_i_Op >= OP_MULT) & (mdu.MDU_i_Op <= OP_DIVU));
    assign mdu.MDU_o_HI       = hi_q;
    assign mdu.MDU_o_LO       = lo_q;
    assign mdu.MDU_o_Result   = mdu.MDU_i_ReadHi ? hi_q : lo_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - scoreboard bench for mdu_sequencer
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    hilo_t       exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_sequencer_if mif ();

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      ps;
        logic [63:0] pu;
        int          sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin
                ps = longint'(sa) * longint'(sb);
                {m_hi, m_lo} = ps;
            end
            3'd2: begin
                pu = {32'd0, a} * {32'd0, b};
                {m_hi, m_lo} = pu;
            end
            3'd3: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            3'd4: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
        exp_q.push_back('{hi: m_hi, lo: m_lo});
    endtask

    task automatic pop_compare(input string tag);
        hilo_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_hi"}, mif.MDU_o_HI, e.hi);
        check({tag, "_lo"}, mif.MDU_o_LO, e.lo);
    endtask

    // Issue a MULT/DIV; inj_cycle > 0 pulses a second Start with inj_op in that busy cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [2:0] inj_op,
                          input int inj_cycle);
        @(negedge clk);
        mif.MDU_i_Start = 1'b1;
        mif.MDU_i_Op    = op;
        mif.MDU_i_A     = a;
        mif.MDU_i_B     = b;
        #1;
        check({tag, "_occ_t"}, 32'(mif.MDU_o_Occupied), 32'd1);
        check({tag, "_busy_t"}, 32'(mif.MDU_o_Busy), 32'd0);
        model_push(op, a, b);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            mif.MDU_i_Start = 1'b0;
            mif.MDU_i_A     = $urandom;
            mif.MDU_i_B     = $urandom;
            if (i == 1 || i == n || i == inj_cycle || i == inj_cycle + 1) begin
                check($sformatf("%s_busy_%0d", tag, i), 32'(mif.MDU_o_Busy), 32'd1);
                check($sformatf("%s_occ_%0d", tag, i), 32'(mif.MDU_o_Occupied), 32'd1);
            end
            if (i == inj_cycle) begin
                mif.MDU_i_Start = 1'b1;
                mif.MDU_i_Op    = inj_op;
            end
        end
        @(negedge clk);
        mif.MDU_i_Start = 1'b0;
        check({tag, "_busy_done"}, 32'(mif.MDU_o_Busy), 32'd0);
        check({tag, "_occ_done"}, 32'(mif.MDU_o_Occupied), 32'd0);
        pop_compare(tag);
    endtask

    task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        mif.MDU_i_Start = 1'b1;
        mif.MDU_i_Op    = op;
        mif.MDU_i_A     = a;
        #1;
        check({tag, "_occ"}, 32'(mif.MDU_o_Occupied), 32'd0);
        model_push(op, a, 32'd0);
        @(negedge clk);
        mif.MDU_i_Start = 1'b0;
        pop_compare(tag);
    endtask

    initial begin
        logic [2:0] rop;
        logic [31:0] ra, rb;
        int         rn;
        reset            = 1'b1;
        mif.MDU_i_Start  = 1'b0;
        mif.MDU_i_Op     = 3'd0;
        mif.MDU_i_A      = 32'd0;
        mif.MDU_i_B      = 32'd0;
        mif.MDU_i_ReadHi = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(mif.MDU_o_Busy), 32'd0);
        check("rst_hi", mif.MDU_o_HI, 32'd0);
        check("rst_lo", mif.MDU_o_LO, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_occ", 32'(mif.MDU_o_Occupied), 32'd0);

        run_op("mult", 3'd1, 32'hFFFF_FFFD, 32'd5, 5, 3'd0, 0);
        check("mult_hi_plan", mif.MDU_o_HI, 32'hFFFF_FFFF);
        check("mult_lo_plan", mif.MDU_o_LO, 32'hFFFF_FFF1);

        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 3'd0, 0);
        check("multu_hi_plan", mif.MDU_o_HI, 32'h0000_0001);
        check("multu_lo_plan", mif.MDU_o_LO, 32'hFFFF_FFFE);

        run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 3'd0, 0);
        check("div_lo_plan", mif.MDU_o_LO, 32'hFFFF_FFFD);
        check("div_hi_plan", mif.MDU_o_HI, 32'hFFFF_FFFF);

        run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 3'd0, 0);
        check("divovf_lo_plan", mif.MDU_o_LO, 32'h8000_0000);
        check("divovf_hi_plan", mif.MDU_o_HI, 32'd0);

        mt_op("mthi1", 3'd5, 32'h1111_1111);
        mt_op("mtlo2", 3'd6, 32'h2222_2222);
        run_op("divz", 3'd4, 32'h1234_5678, 32'd0, 10, 3'd0, 0);
        check("divz_hi_plan", mif.MDU_o_HI, 32'h1111_1111);
        check("divz_lo_plan", mif.MDU_o_LO, 32'h2222_2222);

        mt_op("mthi", 3'd5, 32'hDEAD_BEEF);
        mif.MDU_i_ReadHi = 1'b1;
        #1 check("result_hi", mif.MDU_o_Result, 32'hDEAD_BEEF);
        mif.MDU_i_ReadHi = 1'b0;
        #1 check("result_lo", mif.MDU_o_Result, 32'h2222_2222);

        run_op("mult_mtlo", 3'd1, 32'd7, 32'd9, 5, 3'd6, 2);
        run_op("div_start", 3'd4, 32'd100, 32'd7, 10, 3'd1, 4);
        run_op("op_none_idle", 3'd2, 32'd3, 32'd3, 5, 3'd7, 1);

        for (int k = 0; k < 12; k++) begin
            rop = 3'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (k % 5 == 4) ? 32'd0 : ((k % 2 == 0) ? $urandom : 32'($urandom_range(1, 40)));
            if (k == 3) ra = 32'h8000_0000;
            rn  = (rop <= 3'd2) ? 5 : 10;
            run_op($sformatf("rnd%0d", k), rop, ra, rb, rn, 3'd0, 0);
        end

        mt_op("mthi_pre", 3'd5, 32'h0000_0005);
        @(negedge clk);
        mif.MDU_i_Start = 1'b1;
        mif.MDU_i_Op    = 3'd3;
        mif.MDU_i_A     = 32'd50;
        mif.MDU_i_B     = 32'd3;
        @(negedge clk);
        mif.MDU_i_Start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_busy_pre", 32'(mif.MDU_o_Busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rstmid_busy", 32'(mif.MDU_o_Busy), 32'd0);
        check("rstmid_hi", mif.MDU_o_HI, 32'd0);
        check("rstmid_lo", mif.MDU_o_LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        repeat (12) @(negedge clk);
        check("rstmid_busy_late", 32'(mif.MDU_o_Busy), 32'd0);
        check("rstmid_hi_late", mif.MDU_o_HI, 32'd0);
        check("rstmid_lo_late", mif.MDU_o_LO, 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
